// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding req/ack fetch into a small prefetch FIFO
// that feeds the decoder, with redirect flush and abandoned-request discard.
module fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH   = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic [31:0] o_imem_addr,
   output logic        o_imem_req,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_data,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_stall,
   output logic [31:0] o_opcode,
   output logic [31:0] o_pc,
   output logic        o_valid
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);
   localparam logic [31:0] Nop = 32'h0000_0013;

   typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

   state_e            state_q, state_d;
   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic [31:0]       hold_addr_q, hold_addr_d;
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q, count_d;
   logic [31:0]       fifo_pc_q   [FIFO_DEPTH];
   logic [31:0]       fifo_data_q [FIFO_DEPTH];
   logic              push, pop, has_data;

   assign has_data = (count_q != '0);
   assign push     = (state_q == StReq) && i_imem_ack && !i_redirect;
   assign pop      = has_data && !i_stall && !i_redirect;

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      hold_addr_d = hold_addr_q;
      count_d     = i_redirect ? '0 : count_q + CntW'(push) - CntW'(pop);

      unique case (state_q)
         StIdle: begin
            if (i_redirect || count_q < DepthC) state_d = StReq;
         end
         StReq: begin
            if (i_redirect) begin
               // An unacked request must still complete; park its address and drop its data.
               if (!i_imem_ack) begin
                  state_d     = StDiscard;
                  hold_addr_d = fetch_pc_q;
               end
            end else if (i_imem_ack) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = (count_d < DepthC) ? StReq : StIdle;
            end
         end
         StDiscard: begin
            if (!i_redirect && i_imem_ack) state_d = (count_d < DepthC) ? StReq : StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (i_redirect) fetch_pc_d = i_redirect_pc & ~32'h3;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         fetch_pc_q  <= RESET_VECTOR;
         hold_addr_q <= RESET_VECTOR;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         hold_addr_q <= hold_addr_d;
         count_q     <= count_d;
         if (i_redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]   <= fetch_pc_q;
         fifo_data_q[wr_ptr_q] <= i_imem_data;
      end
   end

   assign o_imem_req  = (state_q != StIdle);
   assign o_imem_addr = (state_q == StDiscard) ? hold_addr_q : fetch_pc_q;
   assign o_valid     = has_data;
   assign o_opcode    = has_data ? fifo_data_q[rd_ptr_q] : Nop;
   assign o_pc        = has_data ? fifo_pc_q[rd_ptr_q] : 32'h0;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage; the producing end of the decode interface. It drives o_opcode and o_pc into the instruction decoder and fetches words from instruction memory over a req/ack handshake. A small prefetch FIFO decouples memory latency from decode stalls. Branch/jump redirects flush the FIFO and restart fetch at the target.

Parameters:
RESET_VECTOR, 32'h00000000, first fetch address after reset
FIFO_DEPTH, 2, prefetch FIFO entries (power of 2, >= 2); each entry holds {pc, instruction}

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
o_imem_addr  output  32  fetch address, word aligned
o_imem_req  output  1  fetch request
i_imem_ack  input  1  memory accepts the request and returns data in the same cycle
i_imem_data  input  32  instruction word, valid when o_imem_req && i_imem_ack
i_redirect  input  1  control-flow change from execute
i_redirect_pc  input  32  redirect target
i_stall  input  1  decode cannot accept this cycle
o_opcode  output  32  instruction to decoder; 32'h00000013 (NOP) when !o_valid
o_pc  output  32  pc of o_opcode; 0 when !o_valid
o_valid  output  1  o_opcode/o_pc hold a real fetched instruction

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_VECTOR, FIFO empty, state IDLE. Outputs: o_imem_req=0, o_imem_addr=RESET_VECTOR, o_valid=0, o_opcode=32'h00000013, o_pc=0.
- Reset mid-request abandons the transfer. The memory must tolerate req dropping without ack.
- States:
  - IDLE: req=0. Next state is REQ when count<FIFO_DEPTH. The first req is asserted 1 cycle after reset release.
  - REQ: req=1, addr=fetch_pc.
    - On ack without redirect: push {fetch_pc, i_imem_data} and set fetch_pc+=4. Stay in REQ if count after this cycle <FIFO_DEPTH, else go to IDLE.
    - No ack: addr and req are held stable.
  - DISCARD: req=1 and addr held at the abandoned address. On ack the data is dropped and the state moves to REQ (or IDLE if full). fetch_pc already holds the redirect target.
- Only one request is outstanding at a time. With zero-wait memory, throughput is 1 instruction/cycle.
- Output side:
  - o_valid = FIFO non-empty; o_opcode/o_pc come from the head entry.
  - Pop when o_valid && !i_stall.
  - There is no bypass: data acked in cycle k is visible at the earliest in cycle k+1.
  - Push and pop may occur in the same cycle; count stays unchanged.
- Redirect (highest priority):
  - FIFO is flushed (count=0) and any same-cycle push or pop is ignored.
  - fetch_pc = {i_redirect_pc[31:2], 2'b00}.
  - o_valid=0 in the following cycle.
  - Redirect in REQ without ack goes to DISCARD.
  - Redirect in REQ with ack: the data is dropped; next state is REQ at the target.
  - Redirect in IDLE goes to REQ.
  - Redirect in DISCARD updates the target and stays in DISCARD.
- fetch_pc wraps modulo 2^32 (32'hFFFFFFFC+4 = 0).
- Count is held in a log2(FIFO_DEPTH)+1 bit counter. Read and write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset release, memory acks every cycle returning data=addr^32'hA5A50000 -> o_imem_addr 0,4,8,...; o_valid rises 1 cycle after the first ack; o_opcode/o_pc sequence matches with no gaps.
- i_stall high 6 cycles, zero-wait memory, FIFO_DEPTH=2 -> req drops after 2 buffered entries; o_opcode holds the head entry; after release the instruction sequence continues with no loss or duplication.
- FIFO full (pc 0x8, 0xC), i_redirect with i_redirect_pc=0x200 -> next cycle o_valid=0, o_opcode=0x00000013, o_pc=0; next addr=0x200; first valid o_pc=0x200.
- Ack delayed 3 cycles at addr 0x10, redirect to 0x40 in cycle 1 of the wait -> addr held at 0x10 until ack; its data never appears on o_opcode; next request addr=0x40.
- Redirect coincident with ack, i_redirect_pc=0x102 -> acked data dropped; next addr=0x100.
- i_rst_n asserted mid-request (req=1, no ack) -> req=0, o_valid=0, o_opcode=0x00000013 immediately, before any clock edge; after release fetch restarts at RESET_VECTOR.
